onchip_mem_arbiter: RTL and testbench

- Upstream front-end for the single-port 2048x32 on-chip RAM used by the tiger_mips core.
- Merges the instruction-fetch master (read-only) and the data master (read/write) onto the RAM's single Avalon-style port.
- Grants one access per cycle, round-robin or data-priority, and stalls the loser with waitrequest.
- Tracks one-cycle read latency and returns readdatavalid to the master that issued the read; also counts contention cycles for performance analysis.

---
 rtl/onchip_mem_arbiter_if.sv | 58 +++++
 rtl/onchip_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter_if
// Bundles the three Avalon-style ports that meet at the on-chip RAM arbiter:
//   i_*   instruction-fetch master (read-only)
//   d_*   data master (read/write)
//   mem_* single port of the 2048x32 on-chip RAM
// Modports:
//   slave  : the arbiter's view (it serves both masters and drives the RAM)
//   master : the surrounding system's view (CPU masters and the RAM itself)
// ---------------------------------------------------------------------------
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  // Instruction master
  logic [ADDR_W-1:0]   i_address;
  logic                i_read;
  logic                i_waitrequest;
  logic [DATA_W-1:0]   i_readdata;
  logic                i_readdatavalid;
  // Data master
  logic [ADDR_W-1:0]   d_address;
  logic                d_read;
  logic                d_write;
  logic [DATA_W/8-1:0] d_byteenable;
  logic [DATA_W-1:0]   d_writedata;
  logic                d_waitrequest;
  logic [DATA_W-1:0]   d_readdata;
  logic                d_readdatavalid;
  // RAM port
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata, i_readdatavalid,
    input  d_address, d_read, d_write, d_byteenable, d_writedata,
    output d_waitrequest, d_readdata, d_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata, i_readdatavalid,
    output d_address, d_read, d_write, d_byteenable, d_writedata,
    input  d_waitrequest, d_readdata, d_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
// Front-end for the single-port on-chip RAM of the tiger_mips core. Merges the
// instruction-fetch master and the data master onto one RAM port, granting at
// most one access per cycle (round-robin or data-priority) and stalling the
// loser with waitrequest. Returns readdatavalid, one cycle after acceptance,
// to the master that issued the read, and counts contention cycles.
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   bus          i_*/d_* master ports and mem_* RAM port (slave modport)
//   conflict_cnt saturating count of cycles where both masters requested
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 32,
  parameter int DATA_PRIORITY = 0,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  onchip_mem_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  grant_e             last_grant_q, last_grant_d;
  logic               i_rdvalid_q, i_rdvalid_d;
  logic               d_rdvalid_q, d_rdvalid_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

  logic               i_req_s, d_req_s;
  logic               i_gnt_s, d_gnt_s;

  assign i_req_s = bus.i_read;
  assign d_req_s = bus.d_read | bus.d_write;

  // Grant selection from the current requests and the previous winner.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    case ({i_req_s, d_req_s})
      2'b10: i_gnt_s = 1'b1;
      2'b01: d_gnt_s = 1'b1;
      2'b11: begin
        if (DATA_PRIORITY != 0) begin
          d_gnt_s = 1'b1;
        end else if (last_grant_q == GNT_D) begin
          i_gnt_s = 1'b1;
        end else begin
          d_gnt_s = 1'b1;
        end
      end
      default: begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
      end
    endcase
  end

  // Next-state for the grant history, read-valid tracking and contention counter.
  always_comb begin
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
    if (i_gnt_s) begin
      last_grant_d = GNT_I;
    end else if (d_gnt_s) begin
      last_grant_d = GNT_D;
    end else begin
      last_grant_d = last_grant_q;
    end
    // Instruction grants are always reads; a data access with write set is a
    // write even if read is also high, so it never returns data.
    i_rdvalid_d = i_gnt_s;
    d_rdvalid_d = d_gnt_s & bus.d_read & ~bus.d_write;
    if (i_req_s && d_req_s && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q   <= GNT_D;
      i_rdvalid_q    <= 1'b0;
      d_rdvalid_q    <= 1'b0;
      conflict_cnt_q <= {CNT_W{1'b0}};
    end else begin
      last_grant_q   <= last_grant_d;
      i_rdvalid_q    <= i_rdvalid_d;
      d_rdvalid_q    <= d_rdvalid_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // RAM drive muxed from the granted master; idle cycles present zeros.
  always_comb begin
    bus.mem_chipselect = i_gnt_s | d_gnt_s;
    bus.mem_write      = d_gnt_s & bus.d_write;
    bus.mem_clken      = 1'b1;
    if (i_gnt_s) begin
      bus.mem_address    = bus.i_address;
      bus.mem_byteenable = {BE_W{1'b1}};
    end else if (d_gnt_s) begin
      bus.mem_address    = bus.d_address;
      bus.mem_byteenable = bus.d_byteenable;
    end else begin
      bus.mem_address    = {ADDR_W{1'b0}};
      bus.mem_byteenable = {BE_W{1'b0}};
    end
    if (i_gnt_s || d_gnt_s) begin
      bus.mem_writedata = bus.d_writedata;
    end else begin
      bus.mem_writedata = {DATA_W{1'b0}};
    end
  end

  // Master-facing handshake and read return; RAM q is shared by both masters.
  always_comb begin
    bus.i_waitrequest   = i_req_s & ~i_gnt_s;
    bus.d_waitrequest   = d_req_s & ~d_gnt_s;
    bus.i_readdatavalid = i_rdvalid_q;
    bus.d_readdatavalid = d_rdvalid_q;
    bus.i_readdata      = bus.mem_readdata;
    bus.d_readdata      = bus.mem_readdata;
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Directed bench for the on-chip RAM arbiter. Instance A is round-robin with a
// 4-bit counter and drives a behavioural 2048x32 RAM; instance B is
// data-priority. Inputs change 1 time unit after the rising edge and outputs
// are sampled a further unit later.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  logic clk;
  logic reset_n;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;
  int tests;
  int fails;

  onchip_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) a_if ();
  onchip_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) b_if ();

  onchip_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .DATA_PRIORITY(0), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave), .conflict_cnt(a_cnt)
  );

  onchip_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .DATA_PRIORITY(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave), .conflict_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: unwritten words read as 0x1000_0000 | address.
  logic [31:0]  ram [0:2047];
  bit   [2047:0] ram_vld;
  logic [31:0]  ram_q;

  function automatic logic [31:0] ram_init(input logic [10:0] addr);
    return 32'h1000_0000 | {21'd0, addr};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_if.mem_clken && a_if.mem_chipselect) begin
      if (a_if.mem_write) begin
        ram[a_if.mem_address] <= merge(ram_vld[a_if.mem_address] ? ram[a_if.mem_address]
                                         : ram_init(a_if.mem_address),
                                       a_if.mem_writedata, a_if.mem_byteenable);
        ram_vld[a_if.mem_address] <= 1'b1;
      end
      ram_q <= ram_vld[a_if.mem_address] ? ram[a_if.mem_address] : ram_init(a_if.mem_address);
    end
  end

  assign a_if.mem_readdata = ram_q;
  assign b_if.mem_readdata = 32'h0000_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    a_if.i_address = 11'd0; a_if.i_read = 1'b0;
    a_if.d_address = 11'd0; a_if.d_read = 1'b0; a_if.d_write = 1'b0;
    a_if.d_byteenable = 4'h0; a_if.d_writedata = 32'h0;
    b_if.i_address = 11'd0; b_if.i_read = 1'b0;
    b_if.d_address = 11'd0; b_if.d_read = 1'b0; b_if.d_write = 1'b0;
    b_if.d_byteenable = 4'h0; b_if.d_writedata = 32'h0;

    // Reset state; combinational path still follows requests during reset.
    #1;
    a_if.i_read = 1'b1; a_if.i_address = 11'h055;
    #1;
    check("rst_cnt",        32'(a_cnt), 32'h0);
    check("rst_i_rdv",      32'(a_if.i_readdatavalid), 32'h0);
    check("rst_d_rdv",      32'(a_if.d_readdatavalid), 32'h0);
    check("rst_clken",      32'(a_if.mem_clken), 32'h1);
    check("rst_i_wait",     32'(a_if.i_waitrequest), 32'h0);
    check("rst_cs",         32'(a_if.mem_chipselect), 32'h1);
    check("rst_addr",       32'(a_if.mem_address), 32'h055);
    a_if.i_read = 1'b0;
    #1;
    check("idle_cs",        32'(a_if.mem_chipselect), 32'h0);
    check("idle_addr",      32'(a_if.mem_address), 32'h0);
    tick(); tick();
    reset_n = 1'b1;

    // Lone instruction read.
    a_if.i_read = 1'b1; a_if.i_address = 11'h010;
    #1;
    check("t1_i_wait",      32'(a_if.i_waitrequest), 32'h0);
    check("t1_addr",        32'(a_if.mem_address), 32'h010);
    check("t1_be",          32'(a_if.mem_byteenable), 32'hF);
    check("t1_write",       32'(a_if.mem_write), 32'h0);
    tick();
    a_if.i_read = 1'b0;
    #1;
    check("t1_i_rdv",       32'(a_if.i_readdatavalid), 32'h1);
    check("t1_i_data",      a_if.i_readdata, 32'h1000_0010);
    check("t1_d_rdv",       32'(a_if.d_readdatavalid), 32'h0);
    tick();
    check("t1_i_rdv_off",   32'(a_if.i_readdatavalid), 32'h0);

    // Partial write then read-back of the top word.
    a_if.d_write = 1'b1; a_if.d_address = 11'h7FF;
    a_if.d_byteenable = 4'h3; a_if.d_writedata = 32'hDEAD_BEEF;
    #1;
    check("t2_d_wait",      32'(a_if.d_waitrequest), 32'h0);
    check("t2_write",       32'(a_if.mem_write), 32'h1);
    check("t2_addr",        32'(a_if.mem_address), 32'h7FF);
    check("t2_be",          32'(a_if.mem_byteenable), 32'h3);
    check("t2_wdata",       a_if.mem_writedata, 32'hDEAD_BEEF);
    tick();
    a_if.d_write = 1'b0; a_if.d_read = 1'b1;
    #1;
    check("t2_wr_no_rdv",   32'(a_if.d_readdatavalid), 32'h0);
    check("t2_rd_write",    32'(a_if.mem_write), 32'h0);
    tick();
    a_if.d_read = 1'b0;
    #1;
    check("t2_d_rdv",       32'(a_if.d_readdatavalid), 32'h1);
    check("t2_d_data",      a_if.d_readdata, 32'h1000_BEEF);
    check("t2_i_rdv",       32'(a_if.i_readdatavalid), 32'h0);
    check("idle_wdata",     a_if.mem_writedata, 32'h0);
    tick();
    check("t2_d_rdv_off",   32'(a_if.d_readdatavalid), 32'h0);

    // Read and write together behave as a write.
    a_if.d_read = 1'b1; a_if.d_write = 1'b1; a_if.d_address = 11'h100;
    a_if.d_byteenable = 4'hF; a_if.d_writedata = 32'h1234_5678;
    #1;
    check("rw_write",       32'(a_if.mem_write), 32'h1);
    tick();
    a_if.d_read = 1'b0; a_if.d_write = 1'b0;
    #1;
    check("rw_no_rdv",      32'(a_if.d_readdatavalid), 32'h0);

    // Instruction wins once so the grant history points at instruction.
    a_if.i_read = 1'b1; a_if.i_address = 11'h011;
    tick();
    a_if.i_read = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Round-robin contention from reset: I, D, I, D.
    a_if.i_read = 1'b1; a_if.i_address = 11'h020;
    a_if.d_read = 1'b1; a_if.d_address = 11'h030;
    #1;
    check("rr1_i_wait",     32'(a_if.i_waitrequest), 32'h0);
    check("rr1_d_wait",     32'(a_if.d_waitrequest), 32'h1);
    check("rr1_addr",       32'(a_if.mem_address), 32'h020);
    tick();
    check("rr2_i_wait",     32'(a_if.i_waitrequest), 32'h1);
    check("rr2_d_wait",     32'(a_if.d_waitrequest), 32'h0);
    check("rr2_addr",       32'(a_if.mem_address), 32'h030);
    check("rr2_i_rdv",      32'(a_if.i_readdatavalid), 32'h1);
    check("rr2_i_data",     a_if.i_readdata, 32'h1000_0020);
    tick();
    check("rr3_i_wait",     32'(a_if.i_waitrequest), 32'h0);
    check("rr3_d_wait",     32'(a_if.d_waitrequest), 32'h1);
    check("rr3_d_rdv",      32'(a_if.d_readdatavalid), 32'h1);
    check("rr3_i_rdv",      32'(a_if.i_readdatavalid), 32'h0);
    check("rr3_d_data",     a_if.d_readdata, 32'h1000_0030);
    tick();
    check("rr4_i_wait",     32'(a_if.i_waitrequest), 32'h1);
    check("rr4_d_wait",     32'(a_if.d_waitrequest), 32'h0);
    check("rr4_i_rdv",      32'(a_if.i_readdatavalid), 32'h1);
    check("rr4_d_rdv",      32'(a_if.d_readdatavalid), 32'h0);
    tick();
    a_if.i_read = 1'b0; a_if.d_read = 1'b0;
    #1;
    check("rr_cnt",         32'(a_cnt), 32'h4);
    check("rr5_d_rdv",      32'(a_if.d_readdatavalid), 32'h1);

    // Counter saturation at all-ones.
    a_if.i_read = 1'b1; a_if.d_read = 1'b1;
    repeat (20) tick();
    a_if.i_read = 1'b0; a_if.d_read = 1'b0;
    #1;
    check("sat_cnt",        32'(a_cnt), 32'hF);
    tick();
    check("sat_hold",       32'(a_cnt), 32'hF);

    // Reset in the cycle after a data read is accepted.
    a_if.d_read = 1'b1; a_if.d_address = 11'h040;
    #1;
    check("rf_d_wait",      32'(a_if.d_waitrequest), 32'h0);
    tick();
    a_if.d_read = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rf_d_rdv_rst",   32'(a_if.d_readdatavalid), 32'h0);
    check("rf_cnt",         32'(a_cnt), 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rf_d_rdv_rel",   32'(a_if.d_readdatavalid), 32'h0);
    a_if.i_read = 1'b1; a_if.i_address = 11'h050;
    a_if.d_read = 1'b1; a_if.d_address = 11'h060;
    #1;
    check("rf_i_wait",      32'(a_if.i_waitrequest), 32'h0);
    check("rf_d_wait2",     32'(a_if.d_waitrequest), 32'h1);
    check("rf_addr",        32'(a_if.mem_address), 32'h050);
    tick();
    a_if.i_read = 1'b0; a_if.d_read = 1'b0;

    // Data priority: data wins every contended cycle.
    b_if.i_read = 1'b1; b_if.i_address = 11'h0AA;
    b_if.d_read = 1'b1; b_if.d_address = 11'h0BB;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("dp_i_wait",    32'(b_if.i_waitrequest), 32'h1);
      check("dp_d_wait",    32'(b_if.d_waitrequest), 32'h0);
      check("dp_addr",      32'(b_if.mem_address), 32'h0BB);
      tick();
    end
    b_if.d_read = 1'b0;
    #1;
    check("dp_i_gnt",       32'(b_if.i_waitrequest), 32'h0);
    check("dp_i_addr",      32'(b_if.mem_address), 32'h0AA);
    check("dp_i_be",        32'(b_if.mem_byteenable), 32'hF);
    tick();
    b_if.i_read = 1'b0;
    #1;
    check("dp_i_rdv",       32'(b_if.i_readdatavalid), 32'h1);
    check("dp_cnt",         32'(b_cnt), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
